// File: rtl/user_pkg.sv
// rtl/user_pkg.sv - user-domain flash constants, OBI subordinate types and flash FSM state
package user_pkg;

  localparam logic [7:0]  FlashCmdRead = 8'h03;
  localparam int unsigned FlashClkDiv  = 2;
  localparam int unsigned FlashCsGap   = 2;
  localparam int unsigned ObiIdWidth   = 4;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [ObiIdWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [ObiIdWidth-1:0] rid;
    logic                  err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef enum logic [2:0] {
    FLASH_IDLE,
    FLASH_SHIFT,
    FLASH_RESP,
    FLASH_GAP,
    FLASH_ERR
  } flash_state_e;

  // The first byte off the wire belongs at the lowest address, so it lands in rdata[7:0].
  function automatic logic [31:0] flash_bytes_le(logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/user_flash_ctrl_shift.sv
// rtl/user_flash_ctrl_shift.sv - 64-bit mode-0 SPI frame shifter (SCK divider, bit counter, MISO capture)
// Ports: clk_i, rst_ni; start_i/tx_i load and launch a frame; done_o pulses on the
// final SCK fall; rx_o holds the last 32 bits sampled; spi_sck_o, spi_mosi_o, spi_miso_i.
module flash_spi_shift #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] tx_i,
  input  logic        spi_miso_i,
  output logic        done_o,
  output logic [31:0] rx_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o
);

  localparam int unsigned      DivW    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  logic            active_q, active_d;
  logic            sck_q, sck_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic [63:0]     shift_q, shift_d;
  logic [31:0]     rx_q, rx_d;
  logic            phase_end;

  always_comb begin
    active_d  = active_q;
    sck_d     = sck_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    done_o    = 1'b0;
    phase_end = active_q && (div_q == DivLast);
    if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      shift_d  = tx_i;
    end else if (active_q) begin
      div_d = phase_end ? '0 : div_q + 1'b1;
      if (phase_end) begin
        sck_d = ~sck_q;
        if (!sck_q) begin
          // Rising SCK: capture MISO. Only the trailing 32 bits survive, which is the data phase.
          rx_d = {rx_q[30:0], spi_miso_i};
        end else begin
          // Falling SCK: advance MOSI so it is settled for the whole next low phase.
          shift_d = {shift_q[62:0], 1'b0};
          if (bit_q == 6'd63) begin
            active_d = 1'b0;
            done_o   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
    end
  end

  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = shift_q[63];
  assign rx_o       = rx_q;

endmodule

// File: rtl/user_flash_ctrl.sv
// rtl/user_flash_ctrl.sv - read-only OBI subordinate issuing single-word SPI NOR READ (0x03) frames
// Ports: clk_i, rst_ni; obi_req_i/obi_rsp_o OBI subordinate port; spi_sck_o, spi_csn_o,
// spi_mosi_o, spi_miso_i flash pins; busy_o high whenever the FSM is not idle.
module user_flash_ctrl
  import user_pkg::*;
#(
  parameter int unsigned ClkDiv    = FlashClkDiv,
  parameter int unsigned CsGap     = FlashCsGap,
  parameter type         obi_req_t = sbr_obi_req_t,
  parameter type         obi_rsp_t = sbr_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     spi_sck_o,
  output logic     spi_csn_o,
  output logic     spi_mosi_o,
  input  logic     spi_miso_i,
  output logic     busy_o
);

  localparam int unsigned      GapW    = (CsGap > 1) ? $clog2(CsGap) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(CsGap - 1);

  flash_state_e          state_q, state_d;
  logic [ObiIdWidth-1:0] aid_q, aid_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  start;
  logic [63:0]           tx;
  logic                  done;
  logic [31:0]           rx;
  logic                  unused_req_bits;

  // Byte enables, write data and the window-select bits never influence a read frame.
  assign unused_req_bits = ^{obi_req_i.a.be, obi_req_i.a.wdata,
                             obi_req_i.a.addr[31:24], obi_req_i.a.addr[1:0]};

  always_comb begin
    state_d   = state_q;
    aid_d     = aid_q;
    gap_d     = gap_q;
    start     = 1'b0;
    tx        = {FlashCmdRead, obi_req_i.a.addr[23:2], 2'b00, 32'h0};
    obi_rsp_o = '0;
    obi_rsp_o.r.rid = aid_q;
    unique case (state_q)
      FLASH_IDLE: begin
        obi_rsp_o.gnt = obi_req_i.req;
        if (obi_req_i.req) begin
          aid_d = obi_req_i.a.aid;
          if (obi_req_i.a.we) begin
            state_d = FLASH_ERR;
          end else begin
            start   = 1'b1;
            state_d = FLASH_SHIFT;
          end
        end
      end
      FLASH_SHIFT: begin
        if (done) state_d = FLASH_RESP;
      end
      FLASH_RESP: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = flash_bytes_le(rx);
        gap_d             = '0;
        state_d           = FLASH_GAP;
      end
      FLASH_GAP: begin
        if (gap_q == GapLast) state_d = FLASH_IDLE;
        else                  gap_d   = gap_q + 1'b1;
      end
      FLASH_ERR: begin
        obi_rsp_o.rvalid = 1'b1;
        obi_rsp_o.r.err  = 1'b1;
        state_d          = FLASH_IDLE;
      end
      default: state_d = FLASH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FLASH_IDLE;
      aid_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      aid_q   <= aid_d;
      gap_q   <= gap_d;
    end
  end

  flash_spi_shift #(
    .ClkDiv(ClkDiv)
  ) u_shift (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start),
    .tx_i      (tx),
    .spi_miso_i(spi_miso_i),
    .done_o    (done),
    .rx_o      (rx),
    .spi_sck_o (spi_sck_o),
    .spi_mosi_o(spi_mosi_o)
  );

  // Decoded from state so an asynchronous reset releases the chip select at once.
  assign spi_csn_o = (state_q != FLASH_SHIFT);
  assign busy_o    = (state_q != FLASH_IDLE);

endmodule

// File: tb/tb_user_flash_ctrl.sv
// tb/tb_user_flash_ctrl.sv - randomized self-checking bench for user_flash_ctrl
module tb_user_flash_ctrl;
  import user_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  sbr_obi_req_t req0, req1;
  sbr_obi_rsp_t rsp0, rsp1;
  logic [1:0]   sck, csn, mosi, busy, miso;

  always #5 clk = ~clk;

  user_flash_ctrl #(.ClkDiv(2), .CsGap(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req0), .obi_rsp_o(rsp0),
    .spi_sck_o(sck[0]), .spi_csn_o(csn[0]), .spi_mosi_o(mosi[0]),
    .spi_miso_i(miso[0]), .busy_o(busy[0])
  );

  user_flash_ctrl #(.ClkDiv(1), .CsGap(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req1), .obi_rsp_o(rsp1),
    .spi_sck_o(sck[1]), .spi_csn_o(csn[1]), .spi_mosi_o(mosi[1]),
    .spi_miso_i(miso[1]), .busy_o(busy[1])
  );

  int unsigned n_tests, n_fail;
  int          cyc;

  // transaction model: one record per instance
  logic        has_txn [2];
  logic        txn_we  [2];
  logic        hs_evt  [2];
  int          hs_cyc  [2];
  int          rv_cyc  [2];
  int          free_cyc[2];
  logic [31:0] exp_rdata[2];
  logic [3:0]  exp_rid [2];
  int          last_off[2];
  logic [31:0] last_rdata[2];
  logic [3:0]  last_rid[2];
  logic        last_err[2];

  // flash model state
  logic [1:0]  p_sck, p_csn;
  int          f_rises[2];
  int          f_ones [2];
  logic [31:0] f_hdr  [2];
  logic [31:0] fr_hdr  [2][8];
  int          fr_rises[2][8];
  int          fr_ones [2][8];
  int          fr_n    [2];

  function automatic int div_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [7:0] mem_byte(logic [23:0] a);
    case (a)
      24'h000104: return 8'hDE;
      24'h000105: return 8'hAD;
      24'h000106: return 8'hBE;
      24'h000107: return 8'hEF;
      default:    return 8'(a * 24'd37) ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic sbr_obi_req_t get_req(int k);
    return (k == 0) ? req0 : req1;
  endfunction

  function automatic sbr_obi_rsp_t get_rsp(int k);
    return (k == 0) ? rsp0 : rsp1;
  endfunction

  task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s[%0d] at cycle %0d: got 0x%0h, expected 0x%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(string name, int k);
    n_tests++;
    n_fail++;
    $display("FAIL %s[%0d] at cycle %0d: timed out waiting", name, k, cyc);
  endtask

  task automatic model_update();
    sbr_obi_req_t r;
    logic [23:0]  a;
    for (int k = 0; k < 2; k++) begin
      r = get_req(k);
      if (!rst_n) begin
        has_txn[k]  = 1'b0;
        free_cyc[k] = 0;
      end else if (r.req && cyc >= free_cyc[k]) begin
        has_txn[k] = 1'b1;
        hs_evt[k]  = 1'b1;
        hs_cyc[k]  = cyc;
        txn_we[k]  = r.a.we;
        exp_rid[k] = r.a.aid;
        if (r.a.we) begin
          rv_cyc[k]    = cyc + 1;
          free_cyc[k]  = cyc + 2;
          exp_rdata[k] = 32'h0;
        end else begin
          a            = {r.a.addr[23:2], 2'b00};
          rv_cyc[k]    = cyc + 1 + 128 * div_of(k);
          free_cyc[k]  = rv_cyc[k] + 1 + gap_of(k);
          exp_rdata[k] = {mem_byte(a + 24'd3), mem_byte(a + 24'd2),
                          mem_byte(a + 24'd1), mem_byte(a)};
        end
      end
    end
    cyc++;
  endtask

  task automatic flash_step(int k);
    logic [23:0] h;
    logic [31:0] word;
    if (!csn[k] && p_csn[k]) begin
      f_rises[k] = 0;
      f_ones[k]  = 0;
      f_hdr[k]   = 32'h0;
    end
    if (csn[k] && !p_csn[k]) begin
      fr_hdr[k][fr_n[k] % 8]   = f_hdr[k];
      fr_rises[k][fr_n[k] % 8] = f_rises[k];
      fr_ones[k][fr_n[k] % 8]  = f_ones[k];
      fr_n[k]++;
    end else if (!csn[k]) begin
      if (sck[k] && !p_sck[k]) begin
        if (f_rises[k] < 32) f_hdr[k] = {f_hdr[k][30:0], mosi[k]};
        else if (mosi[k])    f_ones[k]++;
        f_rises[k]++;
      end
      if (!sck[k] && p_sck[k] && f_rises[k] >= 32 && f_rises[k] < 64) begin
        h    = f_hdr[k][23:0];
        word = {mem_byte(h), mem_byte(h + 24'd1), mem_byte(h + 24'd2), mem_byte(h + 24'd3)};
        miso[k] = word[63 - f_rises[k]];
      end
    end
    p_sck[k] = sck[k];
    p_csn[k] = csn[k];
  endtask

  task automatic compare();
    sbr_obi_rsp_t s;
    sbr_obi_req_t r;
    logic act, win, e_sck;
    int   t, d;
    for (int k = 0; k < 2; k++) begin
      s   = get_rsp(k);
      r   = get_req(k);
      t   = cyc;
      d   = div_of(k);
      act = rst_n && has_txn[k] && t < free_cyc[k];
      win = act && !txn_we[k] && t >= hs_cyc[k] + 1 && t <= hs_cyc[k] + 128 * d;
      e_sck = win ? (((t - hs_cyc[k] - 1) / d) % 2 == 1) : 1'b0;
      chk("gnt",    k, 64'(s.gnt),    64'(r.req && !act));
      chk("rvalid", k, 64'(s.rvalid), 64'(act && t == rv_cyc[k]));
      chk("csn",    k, 64'(csn[k]),   64'(!win));
      chk("sck",    k, 64'(sck[k]),   64'(e_sck));
      chk("busy",   k, 64'(busy[k]),  64'(act && t >= hs_cyc[k] + 1));
      if (!rst_n) chk("rst_mosi", k, 64'(mosi[k]), 64'd0);
      if (act && t == rv_cyc[k]) begin
        chk("rdata", k, 64'(s.r.rdata), 64'(exp_rdata[k]));
        chk("err",   k, 64'(s.r.err),   64'(txn_we[k]));
        chk("rid",   k, 64'(s.r.rid),   64'(exp_rid[k]));
      end
      if (s.rvalid) begin
        last_off[k]   = t - hs_cyc[k];
        last_rdata[k] = s.r.rdata;
        last_rid[k]   = s.r.rid;
        last_err[k]   = s.r.err;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int k = 0; k < 2; k++) flash_step(k);
    compare();
  endtask

  task automatic set_req(int k, logic we, logic [31:0] addr, logic [3:0] aid);
    sbr_obi_req_t r;
    r.req     = 1'b1;
    r.a.addr  = addr;
    r.a.we    = we;
    r.a.be    = 4'($urandom);
    r.a.wdata = $urandom;
    r.a.aid   = aid;
    if (k == 0) req0 = r;
    else        req1 = r;
  endtask

  task automatic drop_req(int k);
    if (k == 0) req0.req = 1'b0;
    else        req1.req = 1'b0;
  endtask

  task automatic issue(int k, logic we, logic [31:0] addr, logic [3:0] aid);
    set_req(k, we, addr, aid);
    hs_evt[k]   = 1'b0;
    last_off[k] = -1;
    for (int i = 0; i < 1000 && !hs_evt[k]; i++) tick();
    if (!hs_evt[k]) timeout_fail("handshake", k);
  endtask

  task automatic wait_idle(int k);
    for (int i = 0; i < 1000 && has_txn[k] && cyc < free_cyc[k]; i++) tick();
    if (has_txn[k] && cyc < free_cyc[k]) timeout_fail("idle", k);
  endtask

  task automatic check_frame(int k, int idx, logic [31:0] exp_hdr);
    chk("frame_hdr",   k, 64'(fr_hdr[k][idx % 8]),   64'(exp_hdr));
    chk("frame_rises", k, 64'(fr_rises[k][idx % 8]), 64'd64);
    chk("frame_ones",  k, 64'(fr_ones[k][idx % 8]),  64'd0);
  endtask

  task automatic read_once(int k, logic [31:0] addr, logic [3:0] aid);
    int n0;
    n0 = fr_n[k];
    issue(k, 1'b0, addr, aid);
    drop_req(k);
    wait_idle(k);
    chk("frame_count", k, 64'(fr_n[k] - n0), 64'd1);
    check_frame(k, fr_n[k] - 1, {FlashCmdRead, addr[23:2], 2'b00});
  endtask

  initial begin
    int          n0, hs_a;
    logic        we;
    logic [31:0] addr;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    req0    = '0;
    req1    = '0;
    miso    = 2'b00;
    p_sck   = 2'b00;
    p_csn   = 2'b11;
    for (int k = 0; k < 2; k++) begin
      has_txn[k] = 1'b0; txn_we[k] = 1'b0; hs_evt[k] = 1'b0;
      hs_cyc[k] = 0; rv_cyc[k] = 0; free_cyc[k] = 0;
      exp_rdata[k] = '0; exp_rid[k] = '0; last_off[k] = -1;
      last_rdata[k] = '0; last_rid[k] = '0; last_err[k] = 1'b0;
      f_rises[k] = 0; f_ones[k] = 0; f_hdr[k] = '0; fr_n[k] = 0;
    end

    repeat (3) tick();
    chk("rst_rsp0", 0, 64'(rsp0), 64'd0);
    chk("rst_rsp1", 1, 64'(rsp1), 64'd0);
    chk("rst_pins", 0, 64'({csn, sck, mosi, busy}), 64'({2'b11, 2'b00, 2'b00, 2'b00}));
    rst_n = 1'b1;
    repeat (2) tick();

    // read of a known word
    read_once(0, 32'h2000_0104, 4'd1);
    chk("t1_rdata", 0, 64'(last_rdata[0]), 64'h0000_0000_EFBE_ADDE);
    chk("t1_rv_at", 0, 64'(last_off[0]),   64'd257);
    chk("t1_hdr",   0, 64'(fr_hdr[0][(fr_n[0] - 1) % 8]), 64'h0300_0104);

    // write is refused without SPI activity
    n0 = fr_n[0];
    issue(0, 1'b1, 32'h2000_0000, 4'd3);
    drop_req(0);
    wait_idle(0);
    chk("t2_rv_at", 0, 64'(last_off[0]), 64'd1);
    chk("t2_err",   0, 64'(last_err[0]), 64'd1);
    chk("t2_rid",   0, 64'(last_rid[0]), 64'd3);
    chk("t2_rdata", 0, 64'(last_rdata[0]), 64'd0);
    chk("t2_frames", 0, 64'(fr_n[0] - n0), 64'd0);

    // unaligned address is word-aligned on the wire
    read_once(0, 32'h2000_0007, 4'd2);
    chk("t3_hdr", 0, 64'(fr_hdr[0][(fr_n[0] - 1) % 8]), 64'h0300_0004);

    // back-to-back reads with req held high
    n0 = fr_n[0];
    issue(0, 1'b0, 32'h2012_3450, 4'd5);
    hs_a = hs_cyc[0];
    issue(0, 1'b0, 32'h20AB_CDE8, 4'd6);
    drop_req(0);
    wait_idle(0);
    chk("t4_hs_gap", 0, 64'(hs_cyc[0] - hs_a), 64'd260);
    chk("t4_rid",    0, 64'(last_rid[0]), 64'd6);
    chk("t4_frames", 0, 64'(fr_n[0] - n0), 64'd2);
    check_frame(0, fr_n[0] - 2, 32'h0312_3450);
    check_frame(0, fr_n[0] - 1, 32'h03AB_CDE8);

    // randomized mix of reads and writes
    for (int i = 0; i < 10; i++) begin
      we   = ($urandom_range(0, 3) == 0);
      addr = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      if (we) begin
        issue(0, 1'b1, addr, 4'($urandom));
        drop_req(0);
        wait_idle(0);
      end else begin
        read_once(0, addr, 4'($urandom));
      end
    end

    // reset during the SCK-high phase of bit 30
    issue(0, 1'b0, 32'h2055_6678, 4'd7);
    drop_req(0);
    hs_a = hs_cyc[0];
    for (int i = 0; i < 400 && cyc < hs_a + 123; i++) tick();
    chk("t6_sck_before", 0, 64'(sck[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_csn_rst", 0, 64'(csn[0]), 64'd1);
    chk("t6_sck_rst", 0, 64'(sck[0]), 64'd0);
    repeat (3) tick();
    chk("t6_no_rv", 0, 64'(last_off[0]), 64'hFFFF_FFFF_FFFF_FFFF);
    rst_n = 1'b1;
    tick();
    read_once(0, 32'h2000_0104, 4'd9);
    chk("t6_rdata", 0, 64'(last_rdata[0]), 64'h0000_0000_EFBE_ADDE);
    chk("t6_rid",   0, 64'(last_rid[0]),   64'd9);

    // ClkDiv=1 instance
    read_once(1, 32'h2000_0104, 4'd4);
    chk("t7_rdata", 1, 64'(last_rdata[1]), 64'h0000_0000_EFBE_ADDE);
    chk("t7_rv_at", 1, 64'(last_off[1]),   64'd129);
    for (int i = 0; i < 3; i++) read_once(1, $urandom, 4'($urandom));

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
